// File: rtl/way_fill_pkg.sv
// way_fill_pkg: shared types and constants for the way fill router.
//   state_t   : refill sequencer states IDLE / FILL / DONE
//   NUM_WAYS  : number of data-array ways
//   WAY_SEL_W : width of a way select
package way_fill_pkg;
  localparam int NUM_WAYS  = 4;
  localparam int WAY_SEL_W = 2;
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
endpackage

// File: rtl/way_dec2to4.sv
// way_dec2to4: 2-bit way select plus enable to 4-bit one-hot way enable.
//   i_sel    : way select 0..3
//   i_en     : enable; low forces an all-zero output
//   o_onehot : one-hot way enable
module way_dec2to4
  import way_fill_pkg::*;
(
  input  logic [WAY_SEL_W-1:0] i_sel,
  input  logic                 i_en,
  output logic [NUM_WAYS-1:0]  o_onehot
);
  assign o_onehot = i_en ? ({{(NUM_WAYS-1){1'b0}}, 1'b1} << i_sel) : '0;
endmodule

// File: rtl/way_fill_router.sv
// way_fill_router: steers a BEATS-beat cache line refill into one of 4 way RAMs.
//   clk, rst_n            : clock, async active-low reset
//   fill_req/idx/way      : start a fill of set fill_idx into way fill_way (IDLE only)
//   in_valid/data/ready   : refill beat handshake
//   way_we/idx/off/data   : registered one-hot RAM write port
//   busy, done            : fill in progress, one-cycle line-complete pulse
//   WAY_FILL_PARITY_EN    : adds in_par (even parity of in_data) and sticky par_err
module way_fill_router
  import way_fill_pkg::*;
#(
  parameter int W     = 64,
  parameter int BEATS = 4,
  parameter int IDX_W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fill_req,
  input  logic [IDX_W-1:0]         fill_idx,
  input  logic [WAY_SEL_W-1:0]     fill_way,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  output logic                     in_ready,
  output logic [NUM_WAYS-1:0]      way_we,
  output logic [IDX_W-1:0]         way_idx,
  output logic [$clog2(BEATS)-1:0] way_off,
  output logic [W-1:0]             way_data,
  output logic                     busy,
  output logic                     done
`ifdef WAY_FILL_PARITY_EN
  ,
  input  logic                     in_par,
  output logic                     par_err
`endif
);
  localparam int OFF_W = $clog2(BEATS);
  state_t                r_state;
  logic [IDX_W-1:0]      r_idx_lat;
  logic [WAY_SEL_W-1:0]  r_way_lat;
  logic [OFF_W-1:0]      r_cnt;
  logic                  w_acc;
  logic                  w_last;
  logic                  w_start;
  logic [NUM_WAYS-1:0]   w_we;
  assign in_ready = r_state == FILL;
  assign busy     = r_state != IDLE;
  assign w_acc    = in_valid && in_ready;
  assign w_last   = r_cnt == OFF_W'(BEATS - 1);
  assign w_start  = r_state == IDLE && fill_req;
  way_dec2to4 u_dec (
    .i_sel    (r_way_lat),
    .i_en     (w_acc),
    .o_onehot (w_we)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx_lat <= '0;
      r_way_lat <= '0;
      r_cnt     <= '0;
      way_we    <= '0;
      way_idx   <= '0;
      way_off   <= '0;
      way_data  <= '0;
      done      <= 1'b0;
    end else begin
      way_we <= w_we;
      done   <= w_acc && w_last;
      if (w_acc) begin
        way_idx  <= r_idx_lat;
        way_off  <= r_cnt;
        way_data <= in_data;
        r_cnt    <= r_cnt + 1'b1;
      end
      case (r_state)
        IDLE: if (fill_req) begin
          r_state   <= FILL;
          r_idx_lat <= fill_idx;
          r_way_lat <= fill_way;
          r_cnt     <= '0;
        end
        FILL:    if (w_acc && w_last) r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef WAY_FILL_PARITY_EN
  // The beat is written regardless; the error only flags the line as suspect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err <= 1'b0;
    else if (w_start) par_err <= 1'b0;
    else if (w_acc && ((^in_data) != in_par)) par_err <= 1'b1;
  end
`else
  logic w_unused;
  assign w_unused = w_start;
`endif
endmodule

// File: tb/tb_way_fill_router.sv
module tb_way_fill_router;
  localparam int W = 64, BEATS = 4, IDX_W = 6;
  typedef struct {
    logic [3:0]  we;
    logic [5:0]  idx;
    logic [1:0]  off;
    logic [63:0] data;
    logic        last;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic fill_req = 1'b0;
  logic [IDX_W-1:0] fill_idx = '0;
  logic [1:0] fill_way = '0;
  logic in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready;
  logic [3:0] way_we;
  logic [IDX_W-1:0] way_idx;
  logic [1:0] way_off;
  logic [W-1:0] way_data;
  logic busy, done;
`ifdef WAY_FILL_PARITY_EN
  logic in_par = 1'b0;
  logic par_err;
  logic bad_par = 1'b0;
`endif
  int n_checks = 0, n_errors = 0;
  exp_t q[$];
  exp_t e;
  logic [3:0] m_we;
  logic [5:0] m_idx;
  logic [1:0] m_cnt;

  way_fill_router #(.W(W), .BEATS(BEATS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .fill_req(fill_req), .fill_idx(fill_idx),
    .fill_way(fill_way), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .way_we(way_we), .way_idx(way_idx),
    .way_off(way_off), .way_data(way_data), .busy(busy), .done(done)
`ifdef WAY_FILL_PARITY_EN
    , .in_par(in_par), .par_err(par_err)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: every write cycle must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_checks++;
      if (way_we !== 4'b0) begin
        if (q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_write: way_we=%b idx=%0d off=%0d, required no write", way_we, way_idx, way_off);
        end else begin
          e = q.pop_front();
          if ({way_we, way_idx, way_off, way_data, done} !== {e.we, e.idx, e.off, e.data, e.last}) begin
            n_errors++;
            $display("FAIL write: got we=%b idx=%0d off=%0d data=%h done=%b, required we=%b idx=%0d off=%0d data=%h done=%b",
                     way_we, way_idx, way_off, way_data, done, e.we, e.idx, e.off, e.data, e.last);
          end
        end
      end else if (done !== 1'b0) begin
        n_errors++;
        $display("FAIL done_without_write: done=%b, required 0", done);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic start_fill(input logic [1:0] w, input logic [5:0] i);
    fill_req = 1'b1; fill_way = w; fill_idx = i;
    @(posedge clk); #1;
    fill_req = 1'b0; fill_way = 2'($urandom); fill_idx = 6'($urandom);
    m_we = 4'b0001 << w; m_idx = i; m_cnt = 2'd0;
    n_checks++;
    if ({busy, in_ready} !== 2'b11) begin
      n_errors++;
      $display("FAIL fill_start: busy=%b in_ready=%b, required 1 1", busy, in_ready);
    end
`ifdef WAY_FILL_PARITY_EN
    n_checks++;
    if (par_err !== 1'b0) begin
      n_errors++;
      $display("FAIL par_err_clear: par_err=%b, required 0", par_err);
    end
`endif
  endtask

  task automatic beat(input logic v, input logic [63:0] d);
    in_valid = v; in_data = d;
`ifdef WAY_FILL_PARITY_EN
    in_par = (^d) ^ bad_par;
`endif
    if (v) begin
      q.push_back('{m_we, m_idx, m_cnt, d, m_cnt == 2'd3});
      m_cnt++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; #2 rst_n = 1'b0; #10;
    n_checks++;
    if ({in_ready, way_we, way_idx, way_off, way_data, busy, done} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: ready=%b we=%b idx=%0d off=%0d data=%h busy=%b done=%b, required all 0",
               in_ready, way_we, way_idx, way_off, way_data, busy, done);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    in_valid = 1'b1; in_data = 64'hDEAD;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, in_ready, way_we} !== 6'b0) begin
      n_errors++;
      $display("FAIL idle_ignores_valid: busy=%b ready=%b we=%b, required 0 0 0000", busy, in_ready, way_we);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    start_fill(2'd1, 6'd9);
    beat(1'b1, 64'h1111_2222_3333_4444);
    beat(1'b1, 64'h5555_6666_7777_8888);
    #5 rst_n = 1'b0;
    in_valid = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, way_we, way_idx, way_off, way_data, busy, done} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_fill: ready=%b we=%b idx=%0d off=%0d busy=%b done=%b, required all 0",
               in_ready, way_we, way_idx, way_off, busy, done);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    n_checks++;
    if ({busy, way_we, done} !== 6'b0 || q.size() != 0) begin
      n_errors++;
      $display("FAIL after_reset_idle: busy=%b we=%b done=%b pending=%0d, required 0 0000 0 0", busy, way_we, done, q.size());
    end
  endtask

  task automatic test_fill_basic();
    start_fill(2'd2, 6'd5);
    for (int i = 0; i < 4; i++) beat(1'b1, {8{8'hA0 + 8'(i)}});
    n_checks++;
    if ({done, busy} !== 2'b11) begin
      n_errors++;
      $display("FAIL basic_done: done=%b busy=%b, required 1 1", done, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({done, busy, in_ready} !== 3'b000) begin
      n_errors++;
      $display("FAIL basic_idle: done=%b busy=%b ready=%b, required 0 0 0", done, busy, in_ready);
    end
  endtask

  task automatic test_gaps();
    logic [6:0] pat;
    pat = 7'b1011001;
    start_fill(2'd0, 6'h2A);
    for (int i = 0; i < 7; i++) beat(pat[i], {$urandom, $urandom});
    n_checks++;
    if ({done, busy} !== 2'b11) begin
      n_errors++;
      $display("FAIL gaps_done: done=%b busy=%b, required 1 1", done, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL gaps_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_ignore_req();
    start_fill(2'd1, 6'd7);
    beat(1'b1, {$urandom, $urandom});
    fill_req = 1'b1; fill_way = 2'd3; fill_idx = 6'd33;
    beat(1'b1, {$urandom, $urandom});
    beat(1'b0, 64'h0);
    beat(1'b1, {$urandom, $urandom});
    fill_req = 1'b0;
    beat(1'b1, {$urandom, $urandom});
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, in_ready} !== 2'b00) begin
      n_errors++;
      $display("FAIL ignore_req_idle: busy=%b ready=%b, required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    start_fill(2'd3, 6'd1);
    for (int i = 0; i < 4; i++) beat(1'b1, {$urandom, $urandom});
    @(posedge clk); #1;
    start_fill(2'd0, 6'd2);
    for (int i = 0; i < 4; i++) beat(1'b1, {$urandom, $urandom});
    n_checks++;
    if (done !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_done: done=%b, required 1", done);
    end
    @(posedge clk); #1;
  endtask

`ifdef WAY_FILL_PARITY_EN
  task automatic test_parity();
    start_fill(2'd2, 6'd3);
    for (int i = 0; i < 4; i++) begin
      bad_par = (i == 2);
      beat(1'b1, {$urandom, $urandom});
      bad_par = 1'b0;
      n_checks++;
      if (par_err !== (i >= 2)) begin
        n_errors++;
        $display("FAIL par_err_beat%0d: par_err=%b, required %b", i, par_err, i >= 2);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (par_err !== 1'b1) begin
      n_errors++;
      $display("FAIL par_err_sticky: par_err=%b, required 1", par_err);
    end
    start_fill(2'd1, 6'd4);
    for (int i = 0; i < 4; i++) beat(1'b1, {$urandom, $urandom});
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_fill_basic();
    test_gaps();
    test_ignore_req();
    test_back_to_back();
    test_reset_mid_fill();
`ifdef WAY_FILL_PARITY_EN
    test_parity();
`endif
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL missing_writes: pending=%0d, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
